// File: rtl/inst_mem_if.sv
// Fetch-side bus of the instruction-memory responder: request/response
// valid/ready handshakes, redirect flush and the program-load write port.
interface inst_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [31:0] resp_pc;
  logic        resp_err;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  modport master (
    output req_valid, req_pc, resp_ready, flush, prog_we, prog_addr, prog_wdata,
    input  req_ready, resp_valid, resp_inst, resp_pc, resp_err
  );

  modport slave (
    input  req_valid, req_pc, resp_ready, flush, prog_we, prog_addr, prog_wdata,
    output req_ready, resp_valid, resp_inst, resp_pc, resp_err
  );
endinterface

// File: rtl/inst_mem_responder.sv
// In-order instruction fetch responder: synchronous read-first word RAM,
// one-cycle in-flight stage and a 2-entry response FIFO with credit-based
// request acceptance. Optional fault checking: INST_MEM_FAULT_CHECK_EN.
module inst_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input logic       clk,
  input logic       rst_n,
  inst_mem_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             req_ready;
  logic             resp_valid;
  logic             accept;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             req_fault;
  logic [2:0]       credit;

  logic             vld_p0;
  logic [31:0]      inst_p0;
  logic [31:0]      pc_p0;
  logic             err_p0;

  logic [31:0]      fifo_inst [2];
  logic [31:0]      fifo_pc   [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

`ifdef INST_MEM_FAULT_CHECK_EN
  logic [1:0]       fifo_err;

  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:IDX_W+2] != '0);
  endfunction

  assign req_fault = addr_fault(bus.req_pc);
  assign wr_en     = bus.prog_we && !addr_fault(bus.prog_addr);
`else
  logic unused_addr_bits;

  // Index wraps modulo DEPTH_WORDS; byte offset and high bits are don't-care.
  assign unused_addr_bits = ^{bus.req_pc[1:0], bus.req_pc[31:IDX_W+2],
                              bus.prog_addr[1:0], bus.prog_addr[31:IDX_W+2]};
  assign req_fault = 1'b0;
  assign wr_en     = bus.prog_we;
`endif

  assign rd_idx = bus.req_pc[IDX_W+1:2];
  assign wr_idx = bus.prog_addr[IDX_W+1:2];

  // Credits: a slot is claimed at accept, so FIFO entries plus the in-flight
  // read may never exceed two; a same-cycle pop frees one slot early.
  assign resp_valid = (count != 2'd0);
  assign pop        = resp_valid && bus.resp_ready;
  assign push       = vld_p0;
  assign credit     = {1'b0, count} + {2'b00, vld_p0} - {2'b00, pop};
  assign req_ready  = rst_n && !bus.flush && (credit < 3'd2);
  assign accept     = bus.req_valid && req_ready;

  // Stage p0: RAM read issued at accept; read-first against a same-cycle write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus.prog_wdata;
    if (accept) begin
      inst_p0 <= mem[rd_idx];
      pc_p0   <= bus.req_pc;
      err_p0  <= req_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (bus.flush) begin
      vld_p0 <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: response FIFO storage; faulting fetches return a NOP
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= err_p0 ? NOP : inst_p0;
      fifo_pc[wr_ptr]   <= pc_p0;
`ifdef INST_MEM_FAULT_CHECK_EN
      fifo_err[wr_ptr]  <= err_p0;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_inst  = resp_valid ? fifo_inst[rd_ptr] : 32'h0;
  assign bus.resp_pc    = resp_valid ? fifo_pc[rd_ptr] : 32'h0;
`ifdef INST_MEM_FAULT_CHECK_EN
  assign bus.resp_err   = resp_valid && fifo_err[rd_ptr];
`else
  assign bus.resp_err   = 1'b0;
`endif

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                !(push && !bus.flush && count == 2'd2));
endmodule
